// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder and its helpers.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fault causes for the trap unit; the fetch side only flags instr_fault today.
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait counter; expired flags the last permitted cycle of a bus wait.
module fetch_timer #(
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(TIMEOUT - 1));
  assign expired    = w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_limit) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/ifetch_resp.sv
// Fetch responder: turns PC-stage requests into handshaked memory beats and
// returns the instruction (or a NOP fault) to decode, stalling the PC meanwhile.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_req,
  input  logic        flush,
  output logic        fetch_stall,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        instr_fault
);

  ifetch_state_e r_state;
  logic [31:0]   r_pc;
  logic          r_mem_req;
  logic [29:0]   r_mem_addr;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic          r_instr_valid;
  logic          r_instr_fault;

  logic w_idle;
  logic w_busy;
  logic w_drain;
  logic w_accept;
  logic w_misalign;
  logic w_expired;
  logic w_timer_en;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_busy     = (r_state == ST_BUSY);
  assign w_drain    = (r_state == ST_DRAIN);
  assign w_accept   = w_idle && fetch_req && is_aligned(fetch_pc) && !flush;
  assign w_misalign = w_idle && fetch_req && !is_aligned(fetch_pc) && !flush;
  // The wait budget spans BUSY and DRAIN together, so a flush does not restart it.
  assign w_timer_en = (w_busy || w_drain) && !mem_ack;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_accept),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  assign fetch_stall = w_accept || (w_busy && !mem_ack) || w_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= NOP;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_instr_fault <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pc       <= fetch_pc;
            r_mem_addr <= fetch_pc[31:2];
            r_mem_req  <= 1'b1;
            r_state    <= ST_BUSY;
          end else if (w_misalign) begin
            r_instr       <= NOP;
            r_instr_pc    <= fetch_pc;
            r_instr_valid <= 1'b1;
            r_instr_fault <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Ack wins over flush and timeout; a flushed ack just drops the data.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
            if (!flush) begin
              r_instr       <= mem_rdata;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_instr_fault <= 1'b0;
            end
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end else if (w_expired) begin
            r_instr       <= NOP;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_instr_fault <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mem_ack || w_expired) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign instr_fault = r_instr_fault;

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp: normal, misaligned, flush, timeout and reset cases.
module tb_ifetch_resp;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush;
  logic        fetch_stall;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_fault;

  int n_checks;
  int n_errors;

  ifetch_resp #(
    .TIMEOUT (16),
    .NOP     (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_pc    (fetch_pc),
    .fetch_req   (fetch_req),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_fault (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    fetch_pc  = '0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(instr_fault), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // Normal fetch: accept 0x100 at cycle 0, ack at cycle 2
    fetch_req = 1'b1; fetch_pc = 32'h100; #1;
    chk("norm_stall_c0", 32'(fetch_stall), 32'd1);
    tick();
    fetch_req = 1'b0; #1;
    chk("norm_mem_req_c1", 32'(mem_req), 32'd1);
    chk("norm_mem_addr_c1", 32'(mem_addr), 32'h40);
    chk("norm_stall_c1", 32'(fetch_stall), 32'd1);
    chk("norm_valid_c1", 32'(instr_valid), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("norm_stall_c2", 32'(fetch_stall), 32'd0);
    chk("norm_mem_addr_c2", 32'(mem_addr), 32'h40);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("norm_valid_c3", 32'(instr_valid), 32'd1);
    chk("norm_instr_c3", instr, 32'hDEADBEEF);
    chk("norm_pc_c3", instr_pc, 32'h100);
    chk("norm_fault_c3", 32'(instr_fault), 32'd0);
    chk("norm_mem_req_c3", 32'(mem_req), 32'd0);
    tick();
    chk("norm_valid_c4", 32'(instr_valid), 32'd0);
    chk("norm_instr_hold", instr, 32'hDEADBEEF);

    // Misaligned request
    fetch_req = 1'b1; fetch_pc = 32'h102; #1;
    chk("mis_stall_c0", 32'(fetch_stall), 32'd0);
    tick();
    fetch_req = 1'b0; #1;
    chk("mis_valid", 32'(instr_valid), 32'd1);
    chk("mis_fault", 32'(instr_fault), 32'd1);
    chk("mis_instr", instr, 32'h13);
    chk("mis_pc", instr_pc, 32'h102);
    chk("mis_mem_req_c1", 32'(mem_req), 32'd0);
    tick();
    chk("mis_valid_c2", 32'(instr_valid), 32'd0);
    chk("mis_mem_req_c2", 32'(mem_req), 32'd0);

    // Flush mid-fetch: drain until ack at cycle 4, new request at cycle 5
    fetch_req = 1'b1; fetch_pc = 32'h200; #1;
    tick();
    fetch_req = 1'b0; flush = 1'b1; #1;
    chk("fl_mem_req_c1", 32'(mem_req), 32'd1);
    chk("fl_stall_c1", 32'(fetch_stall), 32'd1);
    tick();
    flush = 1'b0; #1;
    chk("fl_mem_req_c2", 32'(mem_req), 32'd1);
    chk("fl_stall_c2", 32'(fetch_stall), 32'd1);
    tick();
    flush = 1'b1; #1;
    chk("fl_mem_req_c3", 32'(mem_req), 32'd1);
    chk("fl_stall_c3", 32'(fetch_stall), 32'd1);
    tick();
    flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    chk("fl_mem_req_c4", 32'(mem_req), 32'd1);
    chk("fl_stall_c4", 32'(fetch_stall), 32'd1);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; fetch_req = 1'b1; fetch_pc = 32'h300; #1;
    chk("fl_valid_c5", 32'(instr_valid), 32'd0);
    chk("fl_mem_req_c5", 32'(mem_req), 32'd0);
    chk("fl_instr_hold", instr, 32'h13);
    chk("fl_stall_c5", 32'(fetch_stall), 32'd1);
    tick();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("fl_next_mem_req", 32'(mem_req), 32'd1);
    chk("fl_next_mem_addr", 32'(mem_addr), 32'hC0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("fl_next_valid", 32'(instr_valid), 32'd1);
    chk("fl_next_instr", instr, 32'hCAFEF00D);
    chk("fl_next_pc", instr_pc, 32'h300);

    // Flush coincident with ack
    fetch_req = 1'b1; fetch_pc = 32'h500; #1;
    tick();
    fetch_req = 1'b0; mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    chk("co_stall", 32'(fetch_stall), 32'd0);
    tick();
    mem_ack = 1'b0; flush = 1'b0; mem_rdata = '0; fetch_req = 1'b1; fetch_pc = 32'h600; #1;
    chk("co_valid", 32'(instr_valid), 32'd0);
    chk("co_mem_req", 32'(mem_req), 32'd0);
    chk("co_instr_hold", instr, 32'hCAFEF00D);
    chk("co_idle_accept", 32'(fetch_stall), 32'd1);
    tick();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    chk("co_next_addr", 32'(mem_addr), 32'h180);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("co_next_valid", 32'(instr_valid), 32'd1);
    chk("co_next_instr", instr, 32'h0BADF00D);
    chk("co_next_pc", instr_pc, 32'h600);
    tick();

    // Timeout: no ack, fault pulse 16 cycles after mem_req rises
    fetch_req = 1'b1; fetch_pc = 32'h400; #1;
    tick();
    fetch_req = 1'b0; #1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("to_mem_req_c%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("to_valid_c%0d", i), 32'(instr_valid), 32'd0);
      tick();
    end
    chk("to_valid", 32'(instr_valid), 32'd1);
    chk("to_fault", 32'(instr_fault), 32'd1);
    chk("to_instr", instr, 32'h13);
    chk("to_pc", instr_pc, 32'h400);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_stall", 32'(fetch_stall), 32'd0);
    tick();
    chk("to_valid_after", 32'(instr_valid), 32'd0);

    // Reset asserted between edges during BUSY
    fetch_req = 1'b1; fetch_pc = 32'h800; #1;
    tick();
    fetch_req = 1'b0; #1;
    chk("rb_mem_req_busy", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0; #1;
    chk("rb_mem_req", 32'(mem_req), 32'd0);
    chk("rb_valid", 32'(instr_valid), 32'd0);
    chk("rb_instr", instr, 32'h13);
    chk("rb_fault", 32'(instr_fault), 32'd0);
    chk("rb_stall", 32'(fetch_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_req = 1'b1; fetch_pc = 32'h0; #1;
    chk("rb_new_stall", 32'(fetch_stall), 32'd1);
    tick();
    fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00112233; #1;
    chk("rb_new_mem_req", 32'(mem_req), 32'd1);
    chk("rb_new_addr", 32'(mem_addr), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("rb_new_valid", 32'(instr_valid), 32'd1);
    chk("rb_new_instr", instr, 32'h00112233);
    chk("rb_new_pc", instr_pc, 32'd0);
    chk("rb_new_fault", 32'(instr_fault), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
Name: ifetch_resp

Overview:
- Responder side of the PC fetch interface: accepts the fetch address from the PC stage and drives a handshaked instruction-memory bus.
- Returns the fetched instruction with its PC to the decode stage.
- Generates the stall that feeds the PC register's active-low enable.
- Handles redirect flushes, misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack in BUSY/DRAIN before declaring a fault (must be >= 2)
- NOP, 32'h0000_0013, instruction word returned on fault/reset (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- fetch_pc  in  32  fetch address from PC register (pc_nxt)
- fetch_req  in  1  fetch_pc is valid this cycle
- flush  in  1  redirect (taken branch/jump); squash current fetch
- fetch_stall  out  1  1 = hold PC; wired to PC register en_n
- mem_req  out  1  memory request, registered
- mem_addr  out  30  word address (fetch_pc[31:2]), registered
- mem_ack  in  1  memory has returned data this cycle
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- instr  out  32  fetched instruction, registered
- instr_pc  out  32  PC of instr, registered
- instr_valid  out  1  one-cycle pulse: instr/instr_pc valid
- instr_fault  out  1  qualifies instr_valid: misaligned or timed-out fetch

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mem_req=0, mem_addr=0, instr=NOP, instr_pc=0, instr_valid=0, instr_fault=0, timer=0.
  - Applies immediately, including mid-BUSY/DRAIN; an outstanding memory beat is abandoned.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE:
  - flush=1: nothing accepted that cycle.
  - fetch_req=1 and fetch_pc[1:0]!=0:
    - Next cycle: instr_valid=1, instr_fault=1, instr=NOP, instr_pc=fetch_pc.
    - No mem_req; stay IDLE.
  - fetch_req=1 and aligned:
    - Latch fetch_pc, mem_addr<=fetch_pc[31:2], mem_req<=1, timer<=0; go to BUSY.
- BUSY:
  - mem_req and mem_addr held stable until mem_ack; timer increments each cycle without ack.
  - mem_ack=1 and flush=0: instr<=mem_rdata, instr_pc<=latched PC, instr_valid<=1, instr_fault<=0, mem_req<=0; go to IDLE.
  - mem_ack=1 and flush=1 (same cycle): data discarded, no instr_valid, mem_req<=0; go to IDLE.
  - flush=1 without ack: go to DRAIN; mem_req stays 1.
  - timer==TIMEOUT-1 without ack: instr_valid=1, instr_fault=1, instr=NOP, mem_req<=0; go to IDLE.
- DRAIN:
  - Hold mem_req until mem_ack, then discard data; mem_req<=0; go to IDLE. instr_valid never asserted.
  - Timeout in DRAIN: go to IDLE silently, no fault pulse.
  - Further flush pulses are ignored.
- fetch_stall (combinational):
  - 1 when (IDLE & fetch_req & aligned & !flush) | (BUSY & !mem_ack) | DRAIN; 0 otherwise.
  - Holds the PC from acceptance until the cycle data returns.
- Latency: aligned request accepted at cycle 0, mem_ack at cycle k (k>=1) -> instr_valid at cycle k+1. Minimum 2 cycles.
- instr_valid is a single-cycle pulse. instr, instr_pc and instr_fault hold their last value between pulses.
- Back-to-back: a new request is accepted in the IDLE cycle right after return; no bubble beyond the FSM.

Decomposition:
- Package ifetch_pkg:
  - state enum (IDLE/BUSY/DRAIN)
  - NOP_INSTR constant
  - fault-cause localparams (FAULT_MISALIGN, FAULT_TIMEOUT) for the later trap unit
- Sub-module fetch_timer:
  - saturating counter of width $clog2(TIMEOUT+1)
  - inputs clear/enable; output expired = (count==TIMEOUT-1)
  - reused by the data-side load/store unit

Test Plan:
- Normal fetch: req fetch_pc=0x100 at cycle 0; mem_ack with rdata=0xDEADBEEF at cycle 2 -> mem_addr=0x40; instr_valid at cycle 3 with instr=0xDEADBEEF, instr_pc=0x100, fault=0; fetch_stall=1 for cycles 0-1, 0 at cycle 2.
- Misaligned: req fetch_pc=0x102 -> next cycle instr_valid=1, instr_fault=1, instr=0x13, instr_pc=0x102; mem_req never asserts.
- Flush mid-fetch: req 0x200, flush at cycle 1, mem_ack at cycle 4 with 0x12345678 -> no instr_valid; mem_req held 1-4 then 0; fetch_stall=1 through cycle 4; next req 0x300 accepted at cycle 5.
- Flush coincident with ack: BUSY, mem_ack=1 and flush=1 same cycle -> no instr_valid; IDLE next cycle.
- Timeout: TIMEOUT=16, req 0x400, mem_ack never -> fault pulse with instr=0x13, instr_pc=0x400 exactly 16 cycles after mem_req rose; mem_req drops.
- Reset mid-BUSY: rst_n low between edges during BUSY -> mem_req and instr_valid go 0 immediately, instr=0x13; after release, req 0x0 proceeds normally.
